// File: rtl/nco_pkg.sv
// nco_pkg: constants and helpers shared by the NCO phase bank and its divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   DIV_RST_DEF - divider reload after reset (50 MHz clk / 100 kHz sample rate, minus one)
//   cfg_sel_e   - register select encodings for per-channel writes
//   ch_w()      - channel-index width, never narrower than one bit
package nco_pkg;

   localparam int DIV_RST_DEF = 499;

   typedef enum logic {
      CFG_SEL_INC = 1'b0,   // per-channel phase increment
      CFG_SEL_OFS = 1'b1    // per-channel phase offset (offset build only)
   } cfg_sel_e;

   // A single-channel bank still needs a one-bit index port.
   function automatic int ch_w(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: programmable sample-rate divider producing a one-cycle tick.
// Latency: tick is combinational from the counter; div_wr is seen by the compare one cycle later.
// Backpressure: none, free-running; clr restarts the period and masks a coincident tick.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset (div reloads DIV_RST, counter clears)
//   div_wr     - load div_val into the divider register
//   div_val    - sample period minus one, in clk cycles
//   clr        - restart: counter to zero, tick suppressed this cycle
//   tick       - high in every cycle the counter has reached the divider value
module sample_tick_gen #(
   parameter int DIV_W   = 12,
   parameter int DIV_RST = nco_pkg::DIV_RST_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             div_wr,
   input  logic [DIV_W-1:0] div_val,
   input  logic             clr,
   output logic             tick
);

   logic [DIV_W-1:0] div_q;
   logic [DIV_W-1:0] cnt_q;
   logic             hit;

   // ">=" rather than "==": if the divider is lowered below the current count,
   // the very next compare fires instead of waiting for the counter to wrap.
   assign hit  = (cnt_q >= div_q);
   assign tick = hit & ~clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q <= DIV_W'(DIV_RST);
         cnt_q <= '0;
      end else begin
         if (div_wr) begin
            div_q <= div_val;
         end
         if (clr || hit) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_q + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/nco_phase_bank.sv
// nco_phase_bank: bank of NUM_CH phase accumulators advanced together on each sample tick.
// Latency: phase/wrap/valid update the cycle after a tick; config writes apply from the next tick.
// Backpressure: valid/ready; accumulators never stall, an unaccepted sample is overwritten and flags overrun.
//
// Optional feature: define PHASE_OFFSET_EN to add per-channel offset registers; phase is then
// the accumulator plus offset, registered with the sample. Undefined: phase is the accumulator.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   div_wr, div_val - load sample period minus one
//   cfg_wr, cfg_sel, cfg_ch, cfg_data - per-channel increment (sel=0) / offset (sel=1) write
//   sync_clr        - zero accumulators, wrap, valid and restart the divider
//   phase, wrap     - packed phases (channel 0 in LSBs), per-channel carry-out of last update
//   valid, ready    - sample handshake
//   overrun, overrun_clr - sticky lost-sample flag and its clear
module nco_phase_bank
   import nco_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int PHASE_W = 24,
   parameter int DIV_W   = 12,
   parameter int DIV_RST = DIV_RST_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      div_wr,
   input  logic [DIV_W-1:0]          div_val,
   input  logic                      cfg_wr,
   input  logic                      cfg_sel,
   input  logic [ch_w(NUM_CH)-1:0]   cfg_ch,
   input  logic [PHASE_W-1:0]        cfg_data,
   input  logic                      sync_clr,
   output logic [NUM_CH*PHASE_W-1:0] phase,
   output logic [NUM_CH-1:0]         wrap,
   output logic                      valid,
   input  logic                      ready,
   output logic                      overrun,
   input  logic                      overrun_clr
);

   localparam int CH_W = ch_w(NUM_CH);

   logic               tick;
   logic [PHASE_W-1:0] acc_q [NUM_CH];
   logic [PHASE_W-1:0] inc_q [NUM_CH];
   logic [PHASE_W:0]   sum   [NUM_CH];
   logic [NUM_CH-1:0]  wr_inc;
   logic [NUM_CH-1:0]  wrap_q;
   logic               valid_q;
   logic               overrun_q;
`ifdef PHASE_OFFSET_EN
   logic [NUM_CH-1:0]  wr_ofs;
   logic [PHASE_W-1:0] ofs_q   [NUM_CH];
   logic [PHASE_W-1:0] phase_q [NUM_CH];
`endif

   // sync_clr doubles as the divider restart and masks a coincident tick there,
   // so clear always beats update below without extra gating.
   sample_tick_gen #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
   ) u_tick (
      .clk     (clk),
      .rst_n   (rst_n),
      .div_wr  (div_wr),
      .div_val (div_val),
      .clr     (sync_clr),
      .tick    (tick)
   );

   // Adder with carry-out per channel, and per-channel write decode. Indices at or
   // above NUM_CH match no channel, so out-of-range writes fall away naturally.
   always_comb begin
      wr_inc = '0;
`ifdef PHASE_OFFSET_EN
      wr_ofs = '0;
`endif
      for (int i = 0; i < NUM_CH; i++) begin
         sum[i] = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
         if (cfg_wr && (cfg_ch == CH_W'(i))) begin
            if (cfg_sel == CFG_SEL_INC) begin
               wr_inc[i] = 1'b1;
            end
`ifdef PHASE_OFFSET_EN
            else begin
               wr_ofs[i] = 1'b1;
            end
`endif
         end
      end
   end

   // Accumulators and increments. The tick consumes the increment register's
   // current contents, so a coincident write only shows up on the following tick.
   // Increments are configuration: sync_clr leaves them alone and a coincident write lands.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i] <= '0;
            inc_q[i] <= '0;
         end
         wrap_q <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync_clr) begin
               acc_q[i]  <= '0;
               wrap_q[i] <= 1'b0;
            end else if (tick) begin
               acc_q[i]  <= sum[i][PHASE_W-1:0];
               wrap_q[i] <= sum[i][PHASE_W];
            end
            if (wr_inc[i]) begin
               inc_q[i] <= cfg_data;
            end
         end
      end
   end

   // Sample handshake. A tick always presents a fresh sample; if the previous
   // one is still pending and not being taken this cycle, it is lost -> overrun.
   // A set in the same cycle as overrun_clr keeps the flag up.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         if (sync_clr) begin
            valid_q <= 1'b0;
         end else if (tick) begin
            valid_q <= 1'b1;
         end else if (ready) begin
            valid_q <= 1'b0;
         end

         if (tick && valid_q && !ready) begin
            overrun_q <= 1'b1;
         end else if (overrun_clr) begin
            overrun_q <= 1'b0;
         end
      end
   end

`ifdef PHASE_OFFSET_EN
   // The offset is added to the freshly summed accumulator and registered with
   // the sample, so the output still only moves on a tick. wrap stays the
   // accumulator's own carry; the offset add does not contribute to it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            ofs_q[i]   <= '0;
            phase_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sync_clr) begin
               phase_q[i] <= '0;
            end else if (tick) begin
               phase_q[i] <= sum[i][PHASE_W-1:0] + ofs_q[i];
            end
            if (wr_ofs[i]) begin
               ofs_q[i] <= cfg_data;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_phase
      assign phase[g*PHASE_W +: PHASE_W] = phase_q[g];
   end
`else
   // Accumulators only change on a tick or clear, so they double as the held sample.
   for (genvar g = 0; g < NUM_CH; g++) begin : g_phase
      assign phase[g*PHASE_W +: PHASE_W] = acc_q[g];
   end
`endif

   assign wrap    = wrap_q;
   assign valid   = valid_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_nco_phase_bank.sv
// tb_nco_phase_bank: directed scenarios plus random traffic against a behavioural model.
// Latency: model predicts outputs one clock after the inputs it consumes.
// Backpressure: ready driven by the bench, held or randomised per scenario.
module tb_nco_phase_bank;
   import nco_pkg::*;

   localparam int NCH  = 3;     // 3 channels leaves index 3 unused for out-of-range writes
   localparam int PW   = 24;
   localparam int DW   = 12;
   localparam int DRST = 499;
   localparam int CW   = ch_w(NCH);
   localparam longint unsigned MOD = 64'd1 << PW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            div_wr;
   logic [DW-1:0]   div_val;
   logic            cfg_wr;
   logic            cfg_sel;
   logic [CW-1:0]   cfg_ch;
   logic [PW-1:0]   cfg_data;
   logic            sync_clr;
   logic [NCH*PW-1:0] phase;
   logic [NCH-1:0]  wrap;
   logic            valid;
   logic            ready;
   logic            overrun;
   logic            overrun_clr;

   int checks   = 0;
   int failures = 0;

   // Behavioural model: phases as plain integers, tick timing as elapsed cycles.
   longint unsigned acc_m [NCH];
   longint unsigned inc_m [NCH];
   longint unsigned ofs_m [NCH];
   longint unsigned ph_m  [NCH];
   bit [NCH-1:0]    wrap_m;
   bit              valid_m;
   bit              ovr_m;
   int              elapsed_m;   // cycles since the last tick or restart
   int              div_m;

   always #5 clk = ~clk;

   nco_phase_bank #(
      .NUM_CH  (NCH),
      .PHASE_W (PW),
      .DIV_W   (DW),
      .DIV_RST (DRST)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .div_wr      (div_wr),
      .div_val     (div_val),
      .cfg_wr      (cfg_wr),
      .cfg_sel     (cfg_sel),
      .cfg_ch      (cfg_ch),
      .cfg_data    (cfg_data),
      .sync_clr    (sync_clr),
      .phase       (phase),
      .wrap        (wrap),
      .valid       (valid),
      .ready       (ready),
      .overrun     (overrun),
      .overrun_clr (overrun_clr)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [PW-1:0] ph_dut(input int ch);
      return phase[ch*PW +: PW];
   endfunction

   task automatic compare_all(input string tag);
      for (int ch = 0; ch < NCH; ch++) begin
         chk($sformatf("%s_phase%0d", tag, ch), 64'(ph_dut(ch)), ph_m[ch]);
      end
      chk({tag, "_wrap"},    64'(wrap),    64'(wrap_m));
      chk({tag, "_valid"},   64'(valid),   64'(valid_m));
      chk({tag, "_overrun"}, 64'(overrun), 64'(ovr_m));
   endtask

   task automatic clear_strobes();
      div_wr      = 1'b0;
      cfg_wr      = 1'b0;
      sync_clr    = 1'b0;
      overrun_clr = 1'b0;
   endtask

   // Advance the model by the current inputs, clock the DUT once, compare.
   task automatic step();
      bit tk;
      longint unsigned s;
      tk = !sync_clr && (elapsed_m >= div_m);
      if (tk && valid_m && !ready) ovr_m = 1'b1;
      else if (overrun_clr)         ovr_m = 1'b0;
      if (sync_clr) begin
         for (int ch = 0; ch < NCH; ch++) begin
            acc_m[ch] = 0;
            ph_m[ch]  = 0;
         end
         wrap_m    = '0;
         valid_m   = 1'b0;
         elapsed_m = 0;
      end else if (tk) begin
         for (int ch = 0; ch < NCH; ch++) begin
            s          = acc_m[ch] + inc_m[ch];
            wrap_m[ch] = (s >= MOD);
            acc_m[ch]  = s % MOD;
            ph_m[ch]   = (acc_m[ch] + ofs_m[ch]) % MOD;
         end
         valid_m   = 1'b1;
         elapsed_m = 0;
      end else begin
         elapsed_m++;
         if (ready) valid_m = 1'b0;
      end
      if (div_wr) div_m = int'(div_val);
      if (cfg_wr && (int'(cfg_ch) < NCH)) begin
         if (!cfg_sel) inc_m[cfg_ch] = longint'(cfg_data);
`ifdef PHASE_OFFSET_EN
         else          ofs_m[cfg_ch] = longint'(cfg_data);
`endif
      end
      @(posedge clk);
      #1;
      clear_strobes();
      compare_all("cyc");
   endtask

   task automatic run_until_valid(input string tag, input int max_steps, output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!valid && (n < max_steps));
      if (!valid) chk({tag, "_timeout"}, 64'(valid), 64'd1);
   endtask

   initial begin
      int n;
      logic [PW-1:0] p0;
      logic [PW-1:0] p0_next;

      rst_n    = 1'b0;
      ready    = 1'b0;
      div_val  = '0;
      cfg_sel  = 1'b0;
      cfg_ch   = '0;
      cfg_data = '0;
      clear_strobes();
      for (int ch = 0; ch < NCH; ch++) begin
         acc_m[ch] = 0; inc_m[ch] = 0; ofs_m[ch] = 0; ph_m[ch] = 0;
      end
      wrap_m = '0; valid_m = 1'b0; ovr_m = 1'b0; elapsed_m = 0; div_m = DRST;

      repeat (3) @(posedge clk);
      #1;
      compare_all("rst");
      rst_n = 1'b1;

      // Reset divider value: first sample DIV_RST+1 cycles after release.
      ready = 1'b1;
      run_until_valid("div_rst", 600, n);
      chk("div_rst_period", 64'(n), 64'(DRST + 1));

      // div=4, ch0 inc 0x100, ch1 inc 0x800000 (write lands alongside sync_clr).
      sync_clr = 1'b1; div_wr = 1'b1; div_val = 12'd4;
      cfg_wr = 1'b1; cfg_sel = 1'b0; cfg_ch = 2'd0; cfg_data = 24'h000100;
      step();
      cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_data = 24'h800000;
      step();
      for (int k = 0; k < 4; k++) begin
         run_until_valid("seq", 10, n);
         chk("seq_gap", 64'(n), (k == 0) ? 64'd4 : 64'd5);
         chk("seq_ph0", 64'(ph_dut(0)), 64'((k + 1) * 'h100));
         chk("seq_ph1", 64'(ph_dut(1)), (k % 2 == 0) ? 64'h800000 : 64'h0);
         chk("seq_wrap1", 64'(wrap[1]), 64'(k % 2));
      end

      // Two ticks without ready: second overwrites and flags overrun.
      step();
      ready = 1'b0;
      run_until_valid("ovr_a", 10, n);
      p0 = ph_dut(0);
      p0_next = p0 + 24'h000100;
      repeat (4) step();
      chk("ovr_before", 64'(overrun), 64'd0);
      chk("ovr_hold_ph0", 64'(ph_dut(0)), 64'(p0));
      step();
      chk("ovr_set", 64'(overrun), 64'd1);
      chk("ovr_valid", 64'(valid), 64'd1);
      chk("ovr_ph0", 64'(ph_dut(0)), 64'(p0_next));
      overrun_clr = 1'b1;
      step();
      chk("ovr_clr", 64'(overrun), 64'd0);

      // sync_clr on the tick cycle.
      ready = 1'b1;
      step();
      run_until_valid("realign", 10, n);
      repeat (4) step();
      sync_clr = 1'b1;
      step();
      for (int ch = 0; ch < NCH; ch++) chk("clr_ph", 64'(ph_dut(ch)), 64'd0);
      chk("clr_valid", 64'(valid), 64'd0);
      chk("clr_wrap", 64'(wrap), 64'd0);
      run_until_valid("clr_gap", 20, n);
      chk("clr_gap", 64'(n), 64'd5);
      chk("clr_ph0_next", 64'(ph_dut(0)), 64'h100);

      // Divider lowered to 2 while the counter sits at 7 of 9.
      sync_clr = 1'b1; div_wr = 1'b1; div_val = 12'd9;
      step();
      repeat (7) step();
      div_wr = 1'b1; div_val = 12'd2;
      step();
      chk("div2_pending", 64'(valid), 64'd0);
      run_until_valid("div2_a", 5, n);
      chk("div2_first", 64'(n), 64'd1);
      run_until_valid("div2_b", 10, n);
      chk("div2_gap_b", 64'(n), 64'd3);
      run_until_valid("div2_c", 10, n);
      chk("div2_gap_c", 64'(n), 64'd3);

      // Offset write on ch0 (ignored when the offset feature is absent).
      sync_clr = 1'b1; div_wr = 1'b1; div_val = 12'd4;
      cfg_wr = 1'b1; cfg_sel = 1'b1; cfg_ch = 2'd0; cfg_data = 24'hFFFF00;
      step();
      run_until_valid("ofs", 10, n);
`ifdef PHASE_OFFSET_EN
      chk("ofs_ph0", 64'(ph_dut(0)), 64'h0);
`else
      chk("ofs_ignored_ph0", 64'(ph_dut(0)), 64'h100);
`endif
      chk("ofs_wrap0", 64'(wrap[0]), 64'd0);

      // Random traffic, including out-of-range channel writes.
      for (int i = 0; i < 3000; i++) begin
         ready = ($urandom_range(0, 99) < 60);
         if ($urandom_range(0, 99) < 2) begin
            div_wr = 1'b1; div_val = DW'($urandom_range(0, 7));
         end
         if ($urandom_range(0, 99) < 20) begin
            cfg_wr   = 1'b1;
            cfg_sel  = 1'($urandom_range(0, 1));
            cfg_ch   = CW'($urandom_range(0, 3));
            cfg_data = PW'($urandom);
         end
         if ($urandom_range(0, 99) < 1) sync_clr = 1'b1;
         if ($urandom_range(0, 99) < 8) overrun_clr = 1'b1;
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
